// File: rtl/wb_pkg.sv
// Shared types for the 2x2 Wishbone B4 classic interconnect: FSM states,
// master/slave indices and the per-slave response bundle.
package wb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int N_MST = 2;
    localparam int N_SLV = 2;
    localparam int M0    = 0;
    localparam int M1    = 1;
    localparam int S0    = 0;
    localparam int S1    = 1;

    typedef struct packed {
        logic ack;
        logic err;
        logic rty;
    } wb_resp_t;

    function automatic logic [N_MST-1:0] gnt_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address decoder: one-hot slave select plus miss flag.
// Slave 0 wins when both windows match.
module wb_addr_decode
    import wb_pkg::*;
#(
    parameter logic [31:0] S0_BASE = 32'h1000_0000,
    parameter logic [31:0] S0_MASK = 32'hFFFF_F800,
    parameter logic [31:0] S1_BASE = 32'h4000_0000,
    parameter logic [31:0] S1_MASK = 32'hFFFF_FFF0
) (
    input  logic [31:0]      i_adr,
    output logic [N_SLV-1:0] o_sel,
    output logic             o_miss
);

    logic w_hit0;
    logic w_hit1;

    assign w_hit0    = ((i_adr & S0_MASK) == S0_BASE);
    assign w_hit1    = ((i_adr & S1_MASK) == S1_BASE);
    assign o_sel[S0] = w_hit0;
    assign o_sel[S1] = w_hit1 & ~w_hit0;
    assign o_miss    = ~(w_hit0 | w_hit1);

endmodule

// File: rtl/wb_interconnect.sv
// 2-master x 2-slave Wishbone B4 classic interconnect with round-robin arbitration.
// Optional slave-response timeout enabled by defining WB_ICON_TIMEOUT_EN.
module wb_interconnect
    import wb_pkg::*;
#(
    parameter logic [31:0] S0_BASE = 32'h1000_0000,
    parameter logic [31:0] S0_MASK = 32'hFFFF_F800,
    parameter logic [31:0] S1_BASE = 32'h4000_0000,
    parameter logic [31:0] S1_MASK = 32'hFFFF_FFF0
`ifdef WB_ICON_TIMEOUT_EN
    ,
    parameter int          TIMEOUT = 16
`endif
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  m_cyc_i,
    input  logic [1:0]  m_stb_i,
    input  logic [1:0]  m_we_i,
    input  logic [63:0] m_adr_i,
    input  logic [7:0]  m_sel_i,
    input  logic [63:0] m_dat_i,
    output logic [31:0] m_dat_o,
    output logic [1:0]  m_ack_o,
    output logic [1:0]  m_err_o,
    output logic [1:0]  m_rty_o,
    output logic        s_cyc_o,
    output logic [1:0]  s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    input  logic [63:0] s_dat_i,
    input  logic [1:0]  s_ack_i,
    input  logic [1:0]  s_err_i,
    input  logic [1:0]  s_rty_i
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_grant;
    logic   w_grant_nxt;
    logic   r_last_grant;
    logic   w_last_nxt;

    logic        w_gnt_cyc;
    logic        w_gnt_stb;
    logic        w_gnt_we;
    logic [31:0] w_gnt_adr;
    logic [3:0]  w_gnt_sel;
    logic [31:0] w_gnt_dat;
    logic        w_act;

    logic [N_SLV-1:0] w_sel;
    logic             w_miss;
    wb_resp_t         w_resp;
    logic [31:0]      w_rdata;
    logic             r_miss_err;
    logic             w_to_err;
    logic [1:0]       w_gnt_vec;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
        end
    end

    // Tie goes to whichever master was not served last; the grant holds until its cyc drops.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last_grant;
        case (r_state)
            IDLE: begin
                if (|m_cyc_i) begin
                    w_state_nxt = BUSY;
                    w_grant_nxt = (&m_cyc_i) ? ~r_last_grant : m_cyc_i[M1];
                end
            end
            BUSY: begin
                if (!w_gnt_cyc) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = r_grant;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_gnt_cyc = m_cyc_i[r_grant];
    assign w_gnt_stb = m_stb_i[r_grant];
    assign w_gnt_we  = m_we_i[r_grant];
    assign w_gnt_adr = r_grant ? m_adr_i[63:32] : m_adr_i[31:0];
    assign w_gnt_sel = r_grant ? m_sel_i[7:4]   : m_sel_i[3:0];
    assign w_gnt_dat = r_grant ? m_dat_i[63:32] : m_dat_i[31:0];

    // State resets asynchronously, so everything gated by w_act drops the moment rst_ni falls.
    assign w_act = (r_state == BUSY) & w_gnt_cyc;

    wb_addr_decode #(
        .S0_BASE (S0_BASE),
        .S0_MASK (S0_MASK),
        .S1_BASE (S1_BASE),
        .S1_MASK (S1_MASK)
    ) u_decode (
        .i_adr  (w_gnt_adr),
        .o_sel  (w_sel),
        .o_miss (w_miss)
    );

    assign s_cyc_o = w_act;
    assign s_stb_o = (w_act & w_gnt_stb) ? w_sel : 2'b00;
    assign s_we_o  = w_act & w_gnt_we;
    assign s_adr_o = w_act ? w_gnt_adr : 32'h0;
    assign s_sel_o = w_act ? w_gnt_sel : 4'h0;
    assign s_dat_o = w_act ? w_gnt_dat : 32'h0;

    always_comb begin
        w_resp  = '0;
        w_rdata = 32'h0;
        if (w_sel[S0]) begin
            w_resp  = '{ack: s_ack_i[S0], err: s_err_i[S0], rty: s_rty_i[S0]};
            w_rdata = s_dat_i[31:0];
        end else if (w_sel[S1]) begin
            w_resp  = '{ack: s_ack_i[S1], err: s_err_i[S1], rty: s_rty_i[S1]};
            w_rdata = s_dat_i[63:32];
        end
    end

    // Unmapped strobe: one-cycle err, re-armed every other cycle while stb stays high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_miss_err <= 1'b0;
        end else begin
            r_miss_err <= w_act & w_gnt_stb & w_miss & ~r_miss_err;
        end
    end

`ifdef WB_ICON_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_to_err;
    logic             w_to_run;

    assign w_to_run = w_act & w_gnt_stb & (|w_sel) & ~r_to_err
                    & ~(w_resp.ack | w_resp.err | w_resp.rty);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_to_cnt <= '0;
            r_to_err <= 1'b0;
        end else if (w_to_run) begin
            if (r_to_cnt == CNT_W'(TIMEOUT - 1)) begin
                r_to_cnt <= '0;
                r_to_err <= 1'b1;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
                r_to_err <= 1'b0;
            end
        end else begin
            r_to_cnt <= '0;
            r_to_err <= 1'b0;
        end
    end

    assign w_to_err = r_to_err;
`else
    assign w_to_err = 1'b0;
`endif

    assign w_gnt_vec = gnt_onehot(r_grant);
    assign m_ack_o   = (w_act & w_resp.ack) ? w_gnt_vec : 2'b00;
    assign m_err_o   = (w_act & (w_resp.err | r_miss_err | w_to_err)) ? w_gnt_vec : 2'b00;
    assign m_rty_o   = (w_act & w_resp.rty) ? w_gnt_vec : 2'b00;
    assign m_dat_o   = w_act ? w_rdata : 32'h0;

    // A slave driving ack and err together is passed through but flagged here.
    a_ack_err_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_act && w_resp.ack && w_resp.err));

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed bench for wb_interconnect: a vector table for decode/response muxing
// plus hand-written sequences for arbitration, errors, timeout and reset.
module tb_wb_interconnect;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [63:0] m_adr, m_dat;
    logic [7:0]  m_sel;
    logic [31:0] m_dat_o;
    logic [1:0]  m_ack_o, m_err_o, m_rty_o;
    logic        s_cyc_o;
    logic [1:0]  s_stb_o;
    logic        s_we_o;
    logic [31:0] s_adr_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_o;
    logic [63:0] s_dat;
    logic [1:0]  s_ack, s_err, s_rty;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_interconnect dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_we_i  (m_we),
        .m_adr_i (m_adr),
        .m_sel_i (m_sel),
        .m_dat_i (m_dat),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_rty_o (m_rty_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_sel_o (s_sel_o),
        .s_dat_o (s_dat_o),
        .s_dat_i (s_dat),
        .s_ack_i (s_ack),
        .s_err_i (s_err),
        .s_rty_i (s_rty)
    );

    typedef struct {
        logic [31:0] adr;
        logic        stb;
        logic [1:0]  ack, err, rty;
        logic [31:0] d0, d1;
        logic [1:0]  x_stb, x_ack, x_err, x_rty;
        logic [31:0] x_dat;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
        m_adr = 64'h0; m_dat = 64'h0; m_sel = 8'h0;
        s_dat = 64'h0; s_ack = 2'b00; s_err = 2'b00; s_rty = 2'b00;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int errs;

        tbl[0] = '{32'h1000_0004, 1'b1, 2'b01, 2'b00, 2'b00, 32'hDEAD_BEEF, 32'h1111_1111, 2'b01, 2'b01, 2'b00, 2'b00, 32'hDEAD_BEEF};
        tbl[1] = '{32'h4000_0008, 1'b1, 2'b10, 2'b00, 2'b00, 32'hAAAA_0000, 32'hCAFE_0001, 2'b10, 2'b01, 2'b00, 2'b00, 32'hCAFE_0001};
        tbl[2] = '{32'h1000_07FC, 1'b1, 2'b10, 2'b00, 2'b00, 32'h0000_07FC, 32'hBAD0_BAD0, 2'b01, 2'b00, 2'b00, 2'b00, 32'h0000_07FC};
        tbl[3] = '{32'h1000_0800, 1'b0, 2'b00, 2'b00, 2'b00, 32'h5555_5555, 32'h6666_6666, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0000_0000};
        tbl[4] = '{32'h4000_000F, 1'b1, 2'b00, 2'b10, 2'b00, 32'h3333_3333, 32'h0000_000F, 2'b10, 2'b00, 2'b01, 2'b00, 32'h0000_000F};
        tbl[5] = '{32'h4000_0010, 1'b0, 2'b00, 2'b00, 2'b00, 32'h4444_4444, 32'h7777_7777, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0000_0000};
        tbl[6] = '{32'h1000_0000, 1'b1, 2'b00, 2'b00, 2'b01, 32'h1234_5678, 32'h9999_9999, 2'b01, 2'b00, 2'b00, 2'b01, 32'h1234_5678};
        tbl[7] = '{32'h1000_0000, 1'b1, 2'b01, 2'b10, 2'b00, 32'h8888_8888, 32'h9999_9999, 2'b01, 2'b01, 2'b00, 2'b00, 32'h8888_8888};
        tbl[8] = '{32'h4000_0004, 1'b0, 2'b00, 2'b00, 2'b00, 32'hABCD_0000, 32'h1234_5678, 2'b00, 2'b00, 2'b00, 2'b00, 32'h1234_5678};
        tbl[9] = '{32'h0FFF_FFFF, 1'b0, 2'b00, 2'b00, 2'b00, 32'hEEEE_EEEE, 32'hFFFF_FFFF, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0000_0000};

        // Reset state, even with both masters requesting
        rst_ni = 1'b0;
        idle_inputs();
        m_cyc = 2'b11; m_stb = 2'b11; m_adr = {32'h4000_0000, 32'h1000_0000};
        #1;
        chk("reset_outputs", {s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o, 1'b0, s_we_o},
            32'h0);
        chk("reset_data", m_dat_o | s_adr_o | s_dat_o, 32'h0);
        do_reset();

        // Basic m0 read with arbitration latency
        @(negedge clk);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[31:0] = 32'h1000_0004;
        #1 chk("read_stb_before_grant", s_stb_o, 2'b00);
        @(negedge clk); #1;
        chk("read_stb_after_grant", {s_cyc_o, s_stb_o}, 3'b101);
        s_ack = 2'b01; s_dat[31:0] = 32'hDEAD_BEEF;
        #1;
        chk("read_ack", m_ack_o, 2'b01);
        chk("read_dat", m_dat_o, 32'hDEAD_BEEF);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);

        // Table: m0 holds cyc, vectors exercise decode and response routing
        m_cyc[0] = 1'b1; m_we[0] = 1'b1; m_sel[3:0] = 4'hA; m_dat[31:0] = 32'h0BAD_F00D;
        m_sel[7:4] = 4'h5; m_dat[63:32] = 32'h5555_AAAA;
        @(negedge clk); #1;
        chk("passthru_we_sel", {s_cyc_o, s_we_o, s_sel_o}, 6'b11_1010);
        chk("passthru_dat", s_dat_o, 32'h0BAD_F00D);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            m_adr[31:0] = tbl[i].adr; m_stb[0] = tbl[i].stb;
            s_ack = tbl[i].ack; s_err = tbl[i].err; s_rty = tbl[i].rty;
            s_dat = {tbl[i].d1, tbl[i].d0};
            #1;
            chk($sformatf("vec%0d_flags", i), {s_stb_o, m_ack_o, m_err_o, m_rty_o},
                {tbl[i].x_stb, tbl[i].x_ack, tbl[i].x_err, tbl[i].x_rty});
            chk($sformatf("vec%0d_dat", i), m_dat_o, tbl[i].x_dat);
            chk($sformatf("vec%0d_adr", i), s_adr_o, tbl[i].adr);
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);

        // Round-robin on simultaneous requests after reset: m0, m1, m0, m1
        do_reset();
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            m_cyc = 2'b11; m_stb = 2'b11; m_adr = {32'h4000_0000, 32'h1000_0000};
            @(negedge clk); #1;
            chk($sformatf("rr%0d_grant", r), s_adr_o, (r % 2 == 1) ? 32'h4000_0000 : 32'h1000_0000);
            m_cyc = 2'b00; m_stb = 2'b00;
            @(negedge clk); #1;
            chk($sformatf("rr%0d_dead", r), {31'b0, s_cyc_o}, 32'h0);
        end

        // m1 holds cyc over 3 accesses while m0 waits
        @(negedge clk);
        idle_inputs();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[63:32] = 32'h4000_0000; m_sel[7:4] = 4'hF;
        @(negedge clk);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[31:0] = 32'h1000_0000;
        #1;
        chk("hold_acc0_stb", {s_stb_o, s_adr_o[31:28]}, {2'b10, 4'h4});
        s_ack = 2'b11;
        #1 chk("hold_acc0_ack", m_ack_o, 2'b10);
        for (int a = 1; a < 3; a++) begin
            @(negedge clk);
            s_ack = 2'b00;
            #1 chk($sformatf("hold_acc%0d_stb", a), s_stb_o, 2'b10);
            s_ack = 2'b10;
            #1 chk($sformatf("hold_acc%0d_ack", a), m_ack_o, 2'b10);
        end
        @(negedge clk);
        s_ack = 2'b00; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        @(negedge clk); #1;
        chk("hold_dead_cycle", {31'b0, s_cyc_o}, 32'h0);
        @(negedge clk); #1;
        chk("hold_m0_granted", {s_stb_o, s_adr_o}, {2'b01, 32'h1000_0000});
        idle_inputs();
        @(negedge clk);

        // Unmapped address: registered err one cycle later, one cycle wide
        @(negedge clk);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[31:0] = 32'h2000_0000;
        @(negedge clk); #1;
        chk("miss_no_stb", {s_stb_o, m_err_o}, 4'b0000);
        @(negedge clk); #1;
        chk("miss_err", m_err_o, 2'b01);
        m_stb[0] = 1'b0;
        @(negedge clk); #1;
        chk("miss_err_width", m_err_o, 2'b00);
        idle_inputs();
        @(negedge clk);

        // Unresponsive slave 0
        @(negedge clk);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[31:0] = 32'h1000_0010;
        first = -1;
        errs  = 0;
`ifdef WB_ICON_TIMEOUT_EN
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (m_err_o[0] && first < 0) first = c;
        end
        chk("timeout_err_cycle", first, 16);
`else
        for (int c = 0; c < 100; c++) begin
            @(negedge clk); #1;
            if (m_err_o != 2'b00) errs++;
        end
        chk("no_timeout_err", errs, 0);
        chk("stall_still_active", {s_cyc_o, s_stb_o}, 3'b101);
`endif
        idle_inputs();
        @(negedge clk);

        // Reset mid-access after m0 was last served; m0 must still win after release
        @(negedge clk);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[31:0] = 32'h1000_0000;
        @(negedge clk);
        s_ack = 2'b01;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[31:0] = 32'h1000_0020;
        @(negedge clk); #1;
        chk("rst_pre_active", {s_cyc_o, s_stb_o}, 3'b101);
        rst_ni = 1'b0;
        #1;
        chk("rst_async_gate", {s_cyc_o, s_stb_o, m_ack_o, m_err_o}, 7'b0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_ni = 1'b1;
        m_cyc = 2'b11; m_stb = 2'b11; m_adr = {32'h4000_0000, 32'h1000_0000};
        @(negedge clk); #1;
        chk("rst_m0_wins", s_adr_o, 32'h1000_0000);
        idle_inputs();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
